// File: rtl/seq_decoder_if.sv
// Bundles the sample input and the decoded outputs of seq_decoder.
// Handshake: a sample on sd is consumed on a rising clk edge when in_valid is high.
// There is no back-pressure. bit_valid, byte_valid and err are single-cycle pulses
// with no ready signal. They qualify bit_out, byte_out and the err_cnt increment.
interface seq_decoder_if #(
    parameter int CNT_W = 8
);
    logic             in_valid;
    logic [2:0]       sd;
    logic             locked;
    logic             bit_valid;
    logic             bit_out;
    logic             byte_valid;
    logic [7:0]       byte_out;
    logic             err;
    logic [CNT_W-1:0] err_cnt;

    modport master (
        output in_valid, sd,
        input  locked, bit_valid, bit_out, byte_valid, byte_out, err, err_cnt
    );

    modport slave (
        input  in_valid, sd,
        output locked, bit_valid, bit_out, byte_valid, byte_out, err, err_cnt
    );
endinterface

// File: rtl/seq_decoder.sv
// Decodes the 2/6/7/5/4 state-code trajectory back into the input bit stream.
// The decoder hunts for any legal code and then tracks legal transitions.
// It recovers one bit at each branch point (prev 6 or 4) and packs the bits LSB-first into bytes.
// An illegal code or transition while tracking raises err and drops the decoder back to hunting.
module seq_decoder #(
    parameter int CNT_W = 8
) (
    input logic          clk,
    input logic          reset,
    seq_decoder_if.slave bus
);
    typedef enum logic {
        HUNT  = 1'b0,
        TRACK = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [2:0]       prev_q, prev_d;
    logic [2:0]       bcnt_q, bcnt_d;
    logic [7:0]       shreg_q, shreg_d;
    logic             bit_valid_q, bit_valid_d;
    logic             bit_out_q, bit_out_d;
    logic             byte_valid_q, byte_valid_d;
    logic [7:0]       byte_out_q, byte_out_d;
    logic             err_q, err_d;
    logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
    logic [7:0]       shifted;
    logic             new_bit;
    logic             emit;

    function automatic logic code_legal(input logic [2:0] c);
        return (c == 3'd2) || (c == 3'd4) || (c == 3'd5) || (c == 3'd6) || (c == 3'd7);
    endfunction

    function automatic logic pair_legal(input logic [2:0] p, input logic [2:0] c);
        logic ok;
        case ({p, c})
            {3'd2, 3'd6}, {3'd6, 3'd7}, {3'd6, 3'd5}, {3'd7, 3'd5},
            {3'd5, 3'd4}, {3'd4, 3'd6}, {3'd4, 3'd2}: ok = 1'b1;
            default:                                  ok = 1'b0;
        endcase
        return ok;
    endfunction

    // State and output registers; reset clears everything immediately.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= HUNT;
            prev_q       <= 3'd0;
            bcnt_q       <= 3'd0;
            shreg_q      <= 8'd0;
            bit_valid_q  <= 1'b0;
            bit_out_q    <= 1'b0;
            byte_valid_q <= 1'b0;
            byte_out_q   <= 8'd0;
            err_q        <= 1'b0;
            err_cnt_q    <= '0;
        end else begin
            state_q      <= state_d;
            prev_q       <= prev_d;
            bcnt_q       <= bcnt_d;
            shreg_q      <= shreg_d;
            bit_valid_q  <= bit_valid_d;
            bit_out_q    <= bit_out_d;
            byte_valid_q <= byte_valid_d;
            byte_out_q   <= byte_out_d;
            err_q        <= err_d;
            err_cnt_q    <= err_cnt_d;
        end
    end

    // Next-state: lock on a legal code, recover bits at branch points, drop lock on errors.
    always_comb begin
        state_d      = state_q;
        prev_d       = prev_q;
        bcnt_d       = bcnt_q;
        shreg_d      = shreg_q;
        bit_valid_d  = 1'b0;
        bit_out_d    = bit_out_q;
        byte_valid_d = 1'b0;
        byte_out_d   = byte_out_q;
        err_d        = 1'b0;
        err_cnt_d    = err_cnt_q;
        new_bit      = 1'b0;
        emit         = 1'b0;
        shifted      = shreg_q;

        if (bus.in_valid) begin
            case (state_q)
                HUNT: begin
                    // An illegal code while hunting is silently ignored.
                    if (code_legal(bus.sd)) begin
                        state_d = TRACK;
                        prev_d  = bus.sd;
                    end
                end
                TRACK: begin
                    if (pair_legal(prev_q, bus.sd)) begin
                        prev_d = bus.sd;
                        if (prev_q == 3'd6) begin
                            emit    = 1'b1;
                            new_bit = (bus.sd == 3'd7);
                        end else if (prev_q == 3'd4) begin
                            emit    = 1'b1;
                            new_bit = (bus.sd == 3'd6);
                        end
                        if (emit) begin
                            shifted     = {new_bit, shreg_q[7:1]};
                            shreg_d     = shifted;
                            bit_valid_d = 1'b1;
                            bit_out_d   = new_bit;
                            bcnt_d      = bcnt_q + 3'd1;
                            // The eighth bit publishes the whole byte at once.
                            if (bcnt_q == 3'd7) begin
                                byte_valid_d = 1'b1;
                                byte_out_d   = shifted;
                            end
                        end
                    end else begin
                        err_d   = 1'b1;
                        state_d = HUNT;
                        bcnt_d  = 3'd0;
                        shreg_d = 8'd0;
                        if (err_cnt_q != {CNT_W{1'b1}}) begin
                            err_cnt_d = err_cnt_q + 1'b1;
                        end
                    end
                end
                default: state_d = HUNT;
            endcase
        end
    end

    assign bus.locked     = (state_q == TRACK);
    assign bus.bit_valid  = bit_valid_q;
    assign bus.bit_out    = bit_out_q;
    assign bus.byte_valid = byte_valid_q;
    assign bus.byte_out   = byte_out_q;
    assign bus.err        = err_q;
    assign bus.err_cnt    = err_cnt_q;
endmodule

// File: tb/tb_seq_decoder.sv
// Bench for seq_decoder: directed trajectories plus a random walk.
// Results are compared each cycle against a reference model built from the transition table.
module tb_seq_decoder;
    localparam int CNT_W = 8;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    seq_decoder_if #(.CNT_W(CNT_W)) bus ();
    seq_decoder #(.CNT_W(CNT_W)) dut (.clk(clk), .reset(reset), .bus(bus));

    int n_assert = 0;
    int n_fail   = 0;

    // Reference model: lock flag, last code, pending bits, published byte, error count.
    int legal_pairs[7] = '{'h26, 'h67, 'h65, 'h75, 'h54, 'h46, 'h42};
    bit       m_locked;
    int       m_prev;
    bit       m_bits[$];
    logic [7:0] m_byte;
    int       m_err_cnt;
    bit       e_bv, e_bo, e_byv, e_err;
    bit       obs_bits[$];
    int       n_bytes;

    function automatic bit code_ok(int c);
        return c inside {2, 4, 5, 6, 7};
    endfunction

    function automatic bit pair_ok(int p, int c);
        foreach (legal_pairs[i]) if (legal_pairs[i] == p * 16 + c) return 1'b1;
        return 1'b0;
    endfunction

    // Branch points carry data: from 6 the bit is 1 if the walk goes to 7.
    // From 4 the bit is 1 if the walk goes to 6.
    function automatic int bit_of(int p, int c);
        if (p == 6) return (c == 7) ? 1 : 0;
        if (p == 4) return (c == 6) ? 1 : 0;
        return -1;
    endfunction

    task automatic model_reset();
        m_locked = 0; m_prev = 0; m_bits.delete(); m_byte = 8'h00; m_err_cnt = 0;
        e_bv = 0; e_bo = 0; e_byv = 0; e_err = 0;
    endtask

    task automatic model_update(bit v, int code);
        int b;
        e_bv = 0; e_byv = 0; e_err = 0;
        if (v) begin
            if (!m_locked) begin
                if (code_ok(code)) begin
                    m_locked = 1; m_prev = code;
                end
            end else if (pair_ok(m_prev, code)) begin
                b = bit_of(m_prev, code);
                m_prev = code;
                if (b >= 0) begin
                    e_bv = 1; e_bo = b[0];
                    m_bits.push_back(b[0]);
                    if (m_bits.size() == 8) begin
                        for (int i = 0; i < 8; i++) m_byte[i] = m_bits[i];
                        e_byv = 1;
                        m_bits.delete();
                    end
                end
            end else begin
                e_err = 1;
                if (m_err_cnt < CNT_MAX) m_err_cnt++;
                m_locked = 0;
                m_bits.delete();
            end
        end
    endtask

    task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(bit v, logic [2:0] code);
        @(negedge clk);
        bus.in_valid = v;
        bus.sd       = code;
        model_update(v, int'(code));
        @(posedge clk);
        #1;
        check("locked", 32'(bus.locked), 32'(m_locked));
        check("bit_valid", 32'(bus.bit_valid), 32'(e_bv));
        if (e_bv) check("bit_out", 32'(bus.bit_out), 32'(e_bo));
        check("byte_valid", 32'(bus.byte_valid), 32'(e_byv));
        check("byte_out", 32'(bus.byte_out), 32'(m_byte));
        check("err", 32'(bus.err), 32'(e_err));
        check("err_cnt", 32'(bus.err_cnt), m_err_cnt);
        if (bus.bit_valid) obs_bits.push_back(bus.bit_out);
        if (bus.byte_valid) n_bytes++;
    endtask

    task automatic check_all_zero(string tag);
        check({tag, "_locked"}, 32'(bus.locked), 0);
        check({tag, "_bit_valid"}, 32'(bus.bit_valid), 0);
        check({tag, "_bit_out"}, 32'(bus.bit_out), 0);
        check({tag, "_byte_valid"}, 32'(bus.byte_valid), 0);
        check({tag, "_byte_out"}, 32'(bus.byte_out), 0);
        check({tag, "_err"}, 32'(bus.err), 0);
        check({tag, "_err_cnt"}, 32'(bus.err_cnt), 0);
    endtask

    // Reset is asserted between edges; outputs must clear without waiting for a clock.
    task automatic do_reset();
        @(negedge clk);
        bus.in_valid = 1'b0;
        #2 reset = 1'b0;
        #1 check_all_zero("async_reset");
        model_reset();
        obs_bits.delete();
        n_bytes = 0;
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic run_seq(int seq[$], bit gaps);
        foreach (seq[i]) begin
            step(1'b1, seq[i][2:0]);
            if (gaps) step(1'b0, 3'($urandom_range(0, 7)));
        end
    endtask

    task automatic check_bits(string tag, int exp_b[$]);
        check({tag, "_count"}, obs_bits.size(), exp_b.size());
        if (obs_bits.size() == exp_b.size())
            foreach (exp_b[i]) check({tag, "_bit"}, 32'(obs_bits[i]), exp_b[i]);
    endtask

    initial begin
        int seq28[$] = '{2, 6, 7, 5, 4, 6, 5, 4, 2};
        int bits28[$] = '{1, 1, 0, 0};
        int alt[$];
        int five[$] = '{2, 6, 7, 5, 4, 2, 6, 7, 5, 4, 2, 6, 7};
        int succ[$];
        int code;

        alt.push_back(2);
        for (int k = 0; k < 4; k++) alt = {alt, 6, 7, 5, 4, 2};

        reset = 1'b0;
        bus.in_valid = 1'b0;
        bus.sd = 3'd0;
        model_reset();
        n_bytes = 0;
        #1 check_all_zero("power_on_reset");
        @(negedge clk);
        reset = 1'b1;

        // Basic trajectory recovers 1,1,0,0 without errors.
        do_reset();
        step(1'b1, 3'd2);
        check("lock_after_first", 32'(bus.locked), 1);
        run_seq(seq28[1:$], 1'b0);
        check_bits("traj_bits", bits28);

        // Alternating bits pack to 0x55, one byte pulse.
        do_reset();
        run_seq(alt, 1'b0);
        check("alt_byte", 32'(bus.byte_out), 32'h55);
        check("alt_byte_pulses", n_bytes, 1);

        // Illegal code while tracking, then relock and resume bits.
        do_reset();
        run_seq('{2, 6, 7}, 1'b0);
        step(1'b1, 3'd3);
        check("ill_code_err", 32'(bus.err), 1);
        check("ill_code_cnt", 32'(bus.err_cnt), 1);
        check("ill_code_unlock", 32'(bus.locked), 0);
        obs_bits.delete();
        step(1'b1, 3'd5);
        check("relock_no_bit", 32'(bus.bit_valid), 0);
        run_seq('{4, 6}, 1'b0);
        check_bits("resume_bits", '{1});

        // Illegal transition 2->7 discards partial byte.
        do_reset();
        step(1'b1, 3'd2);
        step(1'b1, 3'd7);
        check("ill_pair_cnt", 32'(bus.err_cnt), 1);
        check("ill_pair_no_byte", n_bytes, 0);

        // Error counter saturates.
        do_reset();
        for (int k = 0; k < 300; k++) begin
            step(1'b1, 3'd2);
            step(1'b1, 3'd2);
        end
        check("err_cnt_sat", 32'(bus.err_cnt), CNT_MAX);

        // Same trajectory with idle cycles in between.
        do_reset();
        run_seq(seq28, 1'b1);
        check_bits("gap_bits", bits28);

        // Reset after five bits, then a fresh byte.
        do_reset();
        run_seq(five, 1'b0);
        check("five_bits", obs_bits.size(), 5);
        do_reset();
        run_seq(alt, 1'b1);
        check("fresh_byte", 32'(bus.byte_out), 32'h55);
        check("fresh_byte_pulses", n_bytes, 1);

        // Random walk with occasional garbage codes and idle cycles.
        do_reset();
        for (int k = 0; k < 3000; k++) begin
            if ($urandom_range(0, 9) == 0) begin
                code = $urandom_range(0, 7);
            end else if (m_locked) begin
                succ.delete();
                foreach (legal_pairs[i]) if (legal_pairs[i] / 16 == m_prev) succ.push_back(legal_pairs[i] % 16);
                code = succ[$urandom_range(0, succ.size() - 1)];
            end else begin
                code = $urandom_range(0, 7);
            end
            step($urandom_range(0, 3) != 0, code[2:0]);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
